ddr4_cmd_monitor: RTL

// - Simulation-side DDR4 command/protocol monitor on the controller-to-DIMM command bus, next to the DIMM model.
// - Parametrised in rank count, bank geometry and timing.
// - Tracks per-rank/per-bank open-row state and timers; flags illegal commands and timing violations.
// - Keeps ACT/RD/WR command counters.

---
 rtl/ddr4_cmd_monitor_if.sv | 16 +
 rtl/ddr4_cmd_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_cmd_monitor_if.sv
// DDR4 command bus as seen by the monitor: ACT_n, address/command pins, bank address, CS_n and CKE.
interface ddr4_cmd_monitor_if #(
    parameter int RANKS   = 1,
    parameter int BG_BITS = 1,
    parameter int BA_BITS = 2
);
    logic                 ddr_act_n;
    logic [16:0]          ddr_adr;
    logic [BG_BITS-1:0]   ddr_bg;
    logic [BA_BITS-1:0]   ddr_ba;
    logic [RANKS-1:0]     ddr_cs_n;
    logic [RANKS-1:0]     ddr_cke;

    modport master (output ddr_act_n, ddr_adr, ddr_bg, ddr_ba, ddr_cs_n, ddr_cke);
    modport slave  (input  ddr_act_n, ddr_adr, ddr_bg, ddr_ba, ddr_cs_n, ddr_cke);
endinterface

// File: rtl/ddr4_cmd_monitor.sv
// DDR4 command/protocol monitor: per-bank open state and timing, error reporting, ACT/RD/WR counters.
// DDR4_MON_STICKY_ERR_EN: latch the first error's code/rank/bank until err_clr or rst.
module ddr4_cmd_monitor #(
    parameter int  RANKS   = 1,
    parameter int  BG_BITS = 1,
    parameter int  BA_BITS = 2,
    parameter int  T_RCD   = 16,
    parameter int  T_RP    = 16,
    parameter int  T_RAS   = 39,
    parameter int  T_RFC   = 420,
    localparam int RW      = (RANKS > 1) ? $clog2(RANKS) : 1,
    localparam int BW      = BG_BITS + BA_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mon_en,
    input  logic              err_clr,
    ddr4_cmd_monitor_if.slave cmd,
    output logic              err_valid,
    output logic [3:0]        err_code,
    output logic [RW-1:0]     err_rank,
    output logic [BW-1:0]     err_bank,
    output logic [15:0]       err_cnt,
    output logic [31:0]       act_cnt,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);
    localparam int NB  = 1 << BW;
    localparam int TA  = (T_RCD > T_RAS) ? T_RCD : T_RAS;
    localparam int TAW = $clog2(TA + 1);
    localparam int TPW = $clog2(T_RP + 1);
    localparam int TRW = $clog2(T_RFC + 1);
    // Timers hold (elapsed cycles - 1): a command exactly T cycles later sees T-1 and passes.
    localparam logic [TAW-1:0] RCD_MIN = TAW'(T_RCD - 1);
    localparam logic [TAW-1:0] RAS_MIN = TAW'(T_RAS - 1);
    localparam logic [TAW-1:0] TA_SAT  = TAW'(TA - 1);
    localparam logic [TPW-1:0] RP_MIN  = TPW'(T_RP - 1);
    localparam logic [TRW-1:0] RFC_MIN = TRW'(T_RFC - 1);

    typedef enum logic [2:0] {K_NONE, K_ACT, K_MRS, K_REF, K_PRE, K_WR, K_RD, K_OTH} kind_e;

    logic [RANKS-1:0][NB-1:0]          open_q, open_d;
    logic [RANKS-1:0][NB-1:0][TAW-1:0] t_act_q, t_act_d;
    logic [RANKS-1:0][NB-1:0][TPW-1:0] t_pre_q, t_pre_d;
    logic [RANKS-1:0][TRW-1:0]         t_ref_q, t_ref_d;

    logic          err_valid_q, err_valid_d;
    logic [3:0]    err_code_q, err_code_d;
    logic [RW-1:0] err_rank_q, err_rank_d;
    logic [BW-1:0] err_bank_q, err_bank_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic [31:0]   act_cnt_q, act_cnt_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
`ifdef DDR4_MON_STICKY_ERR_EN
    logic          sticky_q, sticky_d;
`endif

    logic [RANKS-1:0] cs_low;
    int               n_low;
    logic [RW-1:0]    rk;
    logic [BW-1:0]    bk, eb;
    logic             multi, vld, report;
    kind_e            kind;
    logic [3:0]       code;

    // Row addresses are not tracked: no check depends on which row is open.
    logic unused_adr;
    assign unused_adr = ^{cmd.ddr_adr[13:11], cmd.ddr_adr[9:0]};

    always_comb begin
        cs_low = ~cmd.ddr_cs_n;
        n_low  = 0;
        rk     = '0;
        for (int i = RANKS - 1; i >= 0; i--) begin
            if (cs_low[i]) begin
                n_low = n_low + 1;
                rk    = RW'(i);
            end
        end
        multi = mon_en && (n_low > 1);
        vld   = mon_en && (n_low == 1) && cmd.ddr_cke[rk];
        bk    = {cmd.ddr_bg, cmd.ddr_ba};

        kind = K_NONE;
        if (vld) begin
            if (!cmd.ddr_act_n) kind = K_ACT;
            else begin
                case (cmd.ddr_adr[16:14])
                    3'b000:  kind = K_MRS;
                    3'b001:  kind = K_REF;
                    3'b010:  kind = K_PRE;
                    3'b100:  kind = K_WR;
                    3'b101:  kind = K_RD;
                    default: kind = K_OTH;
                endcase
            end
        end

        open_d  = open_q;
        t_act_d = t_act_q;
        t_pre_d = t_pre_q;
        t_ref_d = t_ref_q;
        if (mon_en) begin
            for (int r = 0; r < RANKS; r++) begin
                if (t_ref_q[r] != RFC_MIN) t_ref_d[r] = t_ref_q[r] + 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (t_act_q[r][b] != TA_SAT) t_act_d[r][b] = t_act_q[r][b] + 1'b1;
                    if (t_pre_q[r][b] != RP_MIN) t_pre_d[r][b] = t_pre_q[r][b] + 1'b1;
                end
            end
        end

        code = 4'd0;
        eb   = bk;
        if (multi) code = 4'd1;
        case (kind)
            K_ACT: begin
                if (open_q[rk][bk])                code = 4'd2;
                else if (t_pre_q[rk][bk] < RP_MIN) code = 4'd3;
                else if (t_ref_q[rk] < RFC_MIN)    code = 4'd4;
                open_d[rk][bk]  = 1'b1;
                t_act_d[rk][bk] = '0;
            end
            K_RD, K_WR: begin
                if (!open_q[rk][bk])                code = 4'd5;
                else if (t_act_q[rk][bk] < RCD_MIN) code = 4'd6;
                if (cmd.ddr_adr[10] && open_q[rk][bk]) begin
                    open_d[rk][bk]  = 1'b0;
                    t_pre_d[rk][bk] = '0;
                end
            end
            K_PRE: begin
                // Descending scan so the lowest violating bank is the one reported.
                for (int b = NB - 1; b >= 0; b--) begin
                    if (open_q[rk][b] && (cmd.ddr_adr[10] || (BW'(b) == bk))) begin
                        if (t_act_q[rk][b] < RAS_MIN) begin
                            code = 4'd7;
                            eb   = BW'(b);
                        end
                        open_d[rk][b]  = 1'b0;
                        t_pre_d[rk][b] = '0;
                    end
                end
            end
            K_REF: begin
                if (|open_q[rk]) code = 4'd8;
                t_ref_d[rk] = '0;
            end
            K_MRS: begin
                if (|open_q[rk]) code = 4'd9;
            end
            default: ;
        endcase

        act_cnt_d = act_cnt_q + {31'd0, kind == K_ACT};
        rd_cnt_d  = rd_cnt_q  + {31'd0, kind == K_RD};
        wr_cnt_d  = wr_cnt_q  + {31'd0, kind == K_WR};

        err_cnt_d = err_clr ? 16'd0 : err_cnt_q;
        if ((code != 4'd0) && (err_cnt_d != 16'hFFFF)) err_cnt_d = err_cnt_d + 16'd1;
`ifdef DDR4_MON_STICKY_ERR_EN
        sticky_d = err_clr ? 1'b0 : sticky_q;
        report   = (code != 4'd0) && !sticky_d;
        if (report) sticky_d = 1'b1;
`else
        report   = (code != 4'd0);
`endif
        err_valid_d = report;
        err_code_d  = err_code_q;
        err_rank_d  = err_rank_q;
        err_bank_d  = err_bank_q;
        if (report) begin
            err_code_d = code;
            err_rank_d = rk;
            err_bank_d = eb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q      <= '0;
            t_act_q     <= {(RANKS*NB){TA_SAT}};
            t_pre_q     <= {(RANKS*NB){RP_MIN}};
            t_ref_q     <= {RANKS{RFC_MIN}};
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_rank_q  <= '0;
            err_bank_q  <= '0;
            err_cnt_q   <= '0;
            act_cnt_q   <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
`ifdef DDR4_MON_STICKY_ERR_EN
            sticky_q    <= 1'b0;
`endif
        end else begin
            open_q      <= open_d;
            t_act_q     <= t_act_d;
            t_pre_q     <= t_pre_d;
            t_ref_q     <= t_ref_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_rank_q  <= err_rank_d;
            err_bank_q  <= err_bank_d;
            err_cnt_q   <= err_cnt_d;
            act_cnt_q   <= act_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
`ifdef DDR4_MON_STICKY_ERR_EN
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_rank  = err_rank_q;
    assign err_bank  = err_bank_q;
    assign err_cnt   = err_cnt_q;
    assign act_cnt   = act_cnt_q;
    assign rd_cnt    = rd_cnt_q;
    assign wr_cnt    = wr_cnt_q;
endmodule
